code_entry_front: RTL and testbench

- Upstream input stage for the ATM controller.
- Conditions the raw access-code switches (SWI[6:4]) and the card switch (SWI[1]) into clean, one-per-press digits.
- Assembles three digits into a packed code and presents it to the ATM FSM through a valid/ack handshake.
- Enforces press/release discipline, so one held switch value counts as exactly one digit. Abandoned entries time out.

---
 rtl/code_entry_front.sv | 168 ++++++++++++++++
 tb/tb_code_entry_front.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_entry_front.sv
// Access-code entry front end: debounces the code switches, enforces
// press/release discipline, assembles three digits into a packed code and
// offers it to the downstream FSM over a valid/ack handshake.
module code_entry_front #(
   parameter int unsigned STABLE_CYCLES  = 2,   // 1..15
   parameter int unsigned TIMEOUT_CYCLES = 20   // 1..255
) (
   input  logic       clk_2,
   input  logic       reset,
   input  logic       cartao,
   input  logic [2:0] cod_raw,
   input  logic       code_ack,
   output logic [2:0] digit,
   output logic       digit_pulse,
   output logic [1:0] digit_count,
   output logic [8:0] code_out,
   output logic       code_valid,
   output logic       timeout,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      StIdle        = 2'd0,
      StWaitPress   = 2'd1,
      StWaitRelease = 2'd2,
      StHold        = 2'd3
   } state_e;

   localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);
   // tmo_cnt holds the number of counted cycles so far; the edge that would
   // make it TIMEOUT_CYCLES is the one that abandons the entry.
   localparam logic [7:0] TmoLast   = 8'(TIMEOUT_CYCLES - 1);

   state_e     state_q, state_d;
   logic [2:0] cod_prev_q;
   logic [3:0] stab_cnt_q, stab_cnt_d;
   logic [7:0] tmo_cnt_q, tmo_cnt_d;
   logic [2:0] digit_q, digit_d;
   logic       pulse_q, pulse_d;
   logic [1:0] count_q, count_d;
   logic [8:0] code_q, code_d;
   logic       valid_q, valid_d;
   logic       tmo_pulse_q, tmo_pulse_d;

   logic       same;
   logic       stable;

   // Stability counter: clears on any change, saturates at STABLE_CYCLES.
   // "stable" is evaluated on the count this edge reaches, so acceptance
   // happens on the same edge the count saturates.
   always_comb begin
      same = (cod_raw == cod_prev_q);
      stab_cnt_d = 4'd0;
      if (same) begin
         stab_cnt_d = (stab_cnt_q == StableMax) ? stab_cnt_q : stab_cnt_q + 4'd1;
      end
      stable = same && (stab_cnt_d == StableMax);
   end

   // Next-state and registered-output logic of the entry FSM.
   always_comb begin
      state_d     = state_q;
      tmo_cnt_d   = tmo_cnt_q;
      digit_d     = digit_q;
      pulse_d     = 1'b0;
      count_d     = count_q;
      code_d      = code_q;
      valid_d     = 1'b0;
      tmo_pulse_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            count_d   = 2'd0;
            code_d    = 9'd0;
            tmo_cnt_d = 8'd0;
            // A switch already set at insertion must be released first.
            if (cartao) begin
               state_d = StWaitRelease;
            end
         end

         StWaitPress, StWaitRelease: begin
            if (!cartao) begin
               // Card removal beats a simultaneous press or timeout.
               state_d   = StIdle;
               count_d   = 2'd0;
               code_d    = 9'd0;
               tmo_cnt_d = 8'd0;
            end else if (state_q == StWaitPress && stable && cod_raw != 3'd0) begin
               // Accepted press beats a simultaneous timeout.
               digit_d   = cod_raw;
               pulse_d   = 1'b1;
               tmo_cnt_d = 8'd0;
               count_d   = count_q + 2'd1;
               unique case (count_q)
                  2'd0:    code_d[8:6] = cod_raw;
                  2'd1:    code_d[5:3] = cod_raw;
                  default: code_d[2:0] = cod_raw;
               endcase
               state_d = (count_q == 2'd2) ? StHold : StWaitRelease;
            end else if (tmo_cnt_q == TmoLast) begin
               // Entry abandoned; card stays in, start over from release.
               tmo_pulse_d = 1'b1;
               tmo_cnt_d   = 8'd0;
               count_d     = 2'd0;
               code_d      = 9'd0;
               state_d     = StWaitRelease;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
               if (state_q == StWaitRelease && stable && cod_raw == 3'd0) begin
                  state_d = StWaitPress;
               end
            end
         end

         StHold: begin
            // Code is frozen; only a qualified ack releases it, even if the
            // card has been pulled meanwhile.
            if (valid_q && code_ack) begin
               count_d   = 2'd0;
               code_d    = 9'd0;
               tmo_cnt_d = 8'd0;
               state_d   = cartao ? StWaitRelease : StIdle;
            end else begin
               valid_d = 1'b1;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_2) begin
      if (reset) begin
         state_q     <= StIdle;
         cod_prev_q  <= 3'd0;
         stab_cnt_q  <= 4'd0;
         tmo_cnt_q   <= 8'd0;
         digit_q     <= 3'd0;
         pulse_q     <= 1'b0;
         count_q     <= 2'd0;
         code_q      <= 9'd0;
         valid_q     <= 1'b0;
         tmo_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cod_prev_q  <= cod_raw;
         stab_cnt_q  <= stab_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         digit_q     <= digit_d;
         pulse_q     <= pulse_d;
         count_q     <= count_d;
         code_q      <= code_d;
         valid_q     <= valid_d;
         tmo_pulse_q <= tmo_pulse_d;
      end
   end

   assign digit       = digit_q;
   assign digit_pulse = pulse_q;
   assign digit_count = count_q;
   assign code_out    = code_q;
   assign code_valid  = valid_q;
   assign timeout     = tmo_pulse_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_code_entry_front.sv
// Directed bench for code_entry_front (STABLE_CYCLES=2, TIMEOUT_CYCLES=20).
module tb_code_entry_front;

   logic       clk_2 = 1'b0;
   logic       reset;
   logic       cartao;
   logic [2:0] cod_raw;
   logic       code_ack;
   logic [2:0] digit;
   logic       digit_pulse;
   logic [1:0] digit_count;
   logic [8:0] code_out;
   logic       code_valid;
   logic       timeout;
   logic [1:0] state_dbg;

   int vectors = 0;
   int miscompares = 0;
   int pulses;
   int tmos;
   logic [2:0] digs [0:7];

   code_entry_front #(
      .STABLE_CYCLES (2),
      .TIMEOUT_CYCLES(20)
   ) dut (
      .clk_2      (clk_2),
      .reset      (reset),
      .cartao     (cartao),
      .cod_raw    (cod_raw),
      .code_ack   (code_ack),
      .digit      (digit),
      .digit_pulse(digit_pulse),
      .digit_count(digit_count),
      .code_out   (code_out),
      .code_valid (code_valid),
      .timeout    (timeout),
      .state_dbg  (state_dbg)
   );

   always #5 clk_2 = ~clk_2;

   // Advance one edge; outputs are then sampled 1 time unit later.
   task automatic tick();
      @(posedge clk_2);
      #1;
   endtask

   // Hold cod_raw for n edges, recording digit strobes and timeout strobes.
   task automatic apply(input logic [2:0] v, input int n);
      cod_raw = v;
      for (int i = 0; i < n; i++) begin
         tick();
         if (digit_pulse) begin
            if (pulses < 8) digs[pulses] = digit;
            pulses++;
         end
         if (timeout) tmos++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; cartao = 1'b0; cod_raw = 3'd0; code_ack = 1'b0;
      tick(); tick();
      reset = 1'b0;
      vectors++;
      if ({digit, digit_pulse, digit_count, code_out, code_valid, timeout, state_dbg} !== 21'd0) begin
         $display("FAIL reset_outputs: got %h want 0",
                  {digit, digit_pulse, digit_count, code_out, code_valid, timeout, state_dbg});
         miscompares++;
      end
   endtask

   task automatic test_three_digits();
      cartao = 1'b1; pulses = 0; tmos = 0;
      apply(3'd0, 3); apply(3'd1, 3); apply(3'd0, 3); apply(3'd3, 3);
      apply(3'd0, 3); apply(3'd7, 3);
      vectors++;
      if (pulses !== 3) begin
         $display("FAIL entry_pulses: got %0d want 3", pulses); miscompares++;
      end
      vectors++;
      if ({digs[0], digs[1], digs[2]} !== 9'b001_011_111) begin
         $display("FAIL entry_digits: got %b want 001011111", {digs[0], digs[1], digs[2]});
         miscompares++;
      end
      // Pulse edge: HOLD entered, valid not yet up; ack now must be ignored.
      vectors++;
      if ({code_valid, state_dbg, digit_count} !== 5'b0_11_11) begin
         $display("FAIL hold_entry: got %b want 01111", {code_valid, state_dbg, digit_count});
         miscompares++;
      end
      code_ack = 1'b1; cod_raw = 3'd5;
      tick();
      code_ack = 1'b0;
      vectors++;
      if ({code_valid, state_dbg} !== 3'b1_11) begin
         $display("FAIL ack_ignored: got %b want 111", {code_valid, state_dbg}); miscompares++;
      end
      for (int i = 0; i < 5; i++) begin
         cod_raw = 3'(i + 1);
         tick();
         vectors++;
         if ({code_valid, code_out} !== 10'b1_001_011_111) begin
            $display("FAIL hold_cycle%0d: got %b want 1001011111", i, {code_valid, code_out});
            miscompares++;
         end
      end
      code_ack = 1'b1; cod_raw = 3'd5;
      tick();
      code_ack = 1'b0;
      vectors++;
      if ({code_valid, digit_count, state_dbg} !== 5'b0_00_10) begin
         $display("FAIL ack_release: got %b want 00010", {code_valid, digit_count, state_dbg});
         miscompares++;
      end
   endtask

   task automatic test_glitch();
      apply(3'd0, 3);
      vectors++;
      if (state_dbg !== 2'd1) begin
         $display("FAIL to_wait_press: got %0d want 1", state_dbg); miscompares++;
      end
      pulses = 0;
      apply(3'd5, 1); apply(3'd0, 4);
      vectors++;
      if ({pulses[3:0], digit_count} !== 6'd0) begin
         $display("FAIL glitch: got pulses=%0d count=%0d want 0 0", pulses, digit_count);
         miscompares++;
      end
   endtask

   task automatic test_hold_key();
      pulses = 0;
      apply(3'd4, 10);
      vectors++;
      if (pulses !== 1 || digit_count !== 2'd1 || state_dbg !== 2'd2) begin
         $display("FAIL held_key: got pulses=%0d count=%0d st=%0d want 1 1 2",
                  pulses, digit_count, state_dbg);
         miscompares++;
      end
      apply(3'd0, 1); apply(3'd4, 4);
      vectors++;
      if (pulses !== 1) begin
         $display("FAIL short_release: got %0d want 1", pulses); miscompares++;
      end
      apply(3'd0, 3); apply(3'd4, 3);
      vectors++;
      if (pulses !== 2 || digit !== 3'd4 || digit_count !== 2'd2) begin
         $display("FAIL repeat_digit: got pulses=%0d d=%0d count=%0d want 2 4 2",
                  pulses, digit, digit_count);
         miscompares++;
      end
   endtask

   task automatic test_card_drop();
      cartao = 1'b0; cod_raw = 3'd0;
      tick();
      vectors++;
      if ({state_dbg, digit_count, code_out, timeout} !== 14'd0) begin
         $display("FAIL card_drop: got st=%0d count=%0d code=%b tmo=%b want 0 0 0 0",
                  state_dbg, digit_count, code_out, timeout);
         miscompares++;
      end
   endtask

   task automatic test_timeout();
      cartao = 1'b1; pulses = 0;
      apply(3'd0, 2); apply(3'd2, 3);
      tmos = 0;
      apply(3'd0, 19);
      vectors++;
      if (pulses !== 1 || tmos !== 0) begin
         $display("FAIL pre_timeout: got pulses=%0d tmos=%0d want 1 0", pulses, tmos);
         miscompares++;
      end
      tick();
      vectors++;
      if ({timeout, digit_count, state_dbg, code_out} !== 14'b1_00_10_000000000) begin
         $display("FAIL timeout_edge: got tmo=%b count=%0d st=%0d code=%b want 1 0 2 0",
                  timeout, digit_count, state_dbg, code_out);
         miscompares++;
      end
      tick();
      vectors++;
      if (timeout !== 1'b0) begin
         $display("FAIL timeout_width: got %b want 0", timeout); miscompares++;
      end
   endtask

   task automatic test_insert_with_key();
      cartao = 1'b0; cod_raw = 3'd6;
      tick(); tick(); tick();
      cartao = 1'b1; pulses = 0;
      apply(3'd6, 5);
      vectors++;
      if (pulses !== 0 || state_dbg !== 2'd2) begin
         $display("FAIL preset_key: got pulses=%0d st=%0d want 0 2", pulses, state_dbg);
         miscompares++;
      end
      apply(3'd0, 3); apply(3'd6, 3);
      vectors++;
      if (pulses !== 1 || digit !== 3'd6) begin
         $display("FAIL preset_accept: got pulses=%0d d=%0d want 1 6", pulses, digit);
         miscompares++;
      end
   endtask

   task automatic test_reset_in_hold();
      apply(3'd0, 3); apply(3'd1, 3); apply(3'd0, 3); apply(3'd1, 3);
      tick();
      vectors++;
      if ({code_valid, code_out} !== 10'b1_110_001_001) begin
         $display("FAIL same_digits: got %b want 1110001001", {code_valid, code_out});
         miscompares++;
      end
      cartao = 1'b0;
      tick(); tick();
      vectors++;
      if ({code_valid, state_dbg} !== 3'b1_11) begin
         $display("FAIL card_out_hold: got %b want 111", {code_valid, state_dbg});
         miscompares++;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if ({digit, digit_pulse, digit_count, code_out, code_valid, timeout, state_dbg} !== 21'd0) begin
         $display("FAIL reset_hold: got %h want 0",
                  {digit, digit_pulse, digit_count, code_out, code_valid, timeout, state_dbg});
         miscompares++;
      end
   endtask

   initial begin
      test_reset();
      test_three_digits();
      test_glitch();
      test_hold_key();
      test_card_drop();
      test_timeout();
      test_insert_with_key();
      test_reset_in_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
